// File: rtl/codec2_pkg.sv
// codec2_pkg: constants and types shared by the codec2 2400 encoder blocks
// and the quantise-core arbiter (value format, FSM states, codebook sizes).
package codec2_pkg;

    // Q15.16 signed fixed point: N total bits, Q fraction bits.
    localparam int N = 32;
    localparam int Q = 16;

    // Legal scalar codebook sizes handed to the quantise core.
    localparam logic [4:0] M4  = 5'd4;
    localparam logic [4:0] M8  = 5'd8;
    localparam logic [4:0] M16 = 5'd16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/quant_share_arb_if.sv
// quant_share_arb_if: requester-side and core-side signals of the shared
// quantise arbiter. The arbiter uses the master view; the requesters and the
// quantise core together form the slave view.
interface quant_share_arb_if #(
    parameter int N    = codec2_pkg::N,
    parameter int NREQ = 4
);
    // Requester side
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] req_m;
    logic [4*NREQ-1:0] req_order;
    logic [N*NREQ-1:0] req_x;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [3:0]        besti;
    logic              err;

    // Quantise core side
    logic              q_start;
    logic [4:0]        q_m;
    logic [3:0]        q_order;
    logic [N-1:0]      q_x;
    logic [3:0]        q_besti;
    logic              q_done;

    modport master (
        input  req, req_m, req_order, req_x, q_besti, q_done,
        output grant, done, besti, err, q_start, q_m, q_order, q_x
    );

    modport slave (
        output req, req_m, req_order, req_x, q_besti, q_done,
        input  grant, done, besti, err, q_start, q_m, q_order, q_x
    );

endinterface

// File: rtl/quant_share_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Scans the request vector
// starting one past the previous owner and returns the first requester found.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            any
);

    // First set bit at or after last+1, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, otherwise the unassigned paths infer latches.
        winner = '0;
        any    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            automatic int idx = (int'(last) + i) % NREQ;
            if (!any && req[idx]) begin
                winner = IW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quant_share_arb.sv
// quant_share_arb: round-robin arbiter/sequencer sharing one scalar quantise
// core between the codec2 2400 encoder requesters. Grants one requester,
// freezes its operands onto the core, runs the start/done handshake and
// returns the best index with a one-cycle done pulse to the owner.
// Optional watchdog on the core: define QUANT_ARB_TIMEOUT_EN.
module quant_share_arb
    import codec2_pkg::*;
#(
    parameter int N           = codec2_pkg::N,
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input logic               clk,
    input logic               rst,
    quant_share_arb_if.master bus
);

    localparam int IW = $clog2(NREQ);

    // The watchdog counter is 10 bits wide; the limit must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
        $error("quant_share_arb: TIMEOUT_CYC must be in 1..1023");
    end

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [3:0]       besti_q, besti_d;
    logic             q_start_q, q_start_d;
    logic [4:0]       q_m_q, q_m_d;
    logic [3:0]       q_order_q, q_order_d;
    logic [N-1:0]     q_x_q, q_x_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    winner_q, winner_d;
`ifdef QUANT_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    logic [IW-1:0]    pick_winner;
    logic             pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Operand mux: the slices of the requester chosen in IDLE.
    logic [4:0]   sel_m;
    logic [3:0]   sel_order;
    logic [N-1:0] sel_x;

    always_comb begin
        sel_m     = bus.req_m[int'(winner_q)*5 +: 5];
        sel_order = bus.req_order[int'(winner_q)*4 +: 4];
        sel_x     = bus.req_x[int'(winner_q)*N +: N];
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        besti_d   = besti_q;
        q_start_d = q_start_q;
        q_m_d     = q_m_q;
        q_order_d = q_order_q;
        q_x_d     = q_x_q;
        last_d    = last_q;
        winner_d  = winner_q;
`ifdef QUANT_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    winner_d = pick_winner;
                    grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << pick_winner;
                    state_d  = LATCH;
                end
            end
            LATCH: begin
                // Operands are captured once here and stay frozen for RUN.
                q_m_d     = sel_m;
                q_order_d = sel_order;
                q_x_d     = sel_x;
                last_d    = winner_q;
                q_start_d = 1'b1;
                state_d   = RUN;
`ifdef QUANT_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            RUN: begin
                if (bus.q_done) begin
                    q_start_d = 1'b0;
                    besti_d   = bus.q_besti;
                    done_d    = grant_q;
                    state_d   = RESP;
                end
`ifdef QUANT_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // Core never answered: release it with a null result.
                    q_start_d = 1'b0;
                    besti_d   = '0;
                    err_d     = 1'b1;
                    done_d    = grant_q;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
`endif
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; an asynchronous reset aborts any job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            besti_q   <= '0;
            q_start_q <= 1'b0;
            q_m_q     <= '0;
            q_order_q <= '0;
            q_x_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            winner_q  <= '0;
`ifdef QUANT_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            besti_q   <= besti_d;
            q_start_q <= q_start_d;
            q_m_q     <= q_m_d;
            q_order_q <= q_order_d;
            q_x_q     <= q_x_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
`ifdef QUANT_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.besti   = besti_q;
    assign bus.q_start = q_start_q;
    assign bus.q_m     = q_m_q;
    assign bus.q_order = q_order_q;
    assign bus.q_x     = q_x_q;
`ifdef QUANT_ARB_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_quant_share_arb.sv
// tb_quant_share_arb: directed scoreboard bench for quant_share_arb with a
// behavioural quantise core. The timeout step runs when QUANT_ARB_TIMEOUT_EN
// is defined for the whole build.
module tb_quant_share_arb;
    import codec2_pkg::*;

    localparam int NREQ = 4;
    localparam int TO   = 50;

    typedef struct {
        int         idx;
        logic [3:0] besti;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    quant_share_arb_if #(.N(N), .NREQ(NREQ)) bus ();

    quant_share_arb #(
        .N           (N),
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic req_b [NREQ];
    int   rearm [NREQ];

    // Core model knobs
    int         core_delay  = 5;
    logic       core_hang   = 1'b0;
    logic       core_fix_en = 1'b0;
    logic [3:0] core_fix    = '0;
    int         core_cnt    = 0;

    always_comb begin
        for (int k = 0; k < NREQ; k++) bus.req[k] = req_b[k];
    end

    function automatic logic [3:0] model_besti(input logic [N-1:0] x, input logic [3:0] order);
        return x[3:0] ^ x[19:16] ^ order;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input int k, input logic [4:0] m, input logic [3:0] order, input logic [N-1:0] x);
        bus.req_m[k*5 +: 5]     = m;
        bus.req_order[k*4 +: 4] = order;
        bus.req_x[k*N +: N]     = x;
    endtask

    task automatic push(input int k, input logic [3:0] besti, input logic err);
        exp_t e;
        e.idx = k; e.besti = besti; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clk);
        check(tag, sb.size(), 0);
        sb.delete();
        for (int k = 0; k < NREQ; k++) begin req_b[k] = 1'b0; rearm[k] = 0; end
    endtask

    task automatic wait_start(input string tag, input int budget);
        for (int c = 0; c < budget && !bus.q_start; c++) @(negedge clk);
        check(tag, bus.q_start, 1);
    endtask

    // Behavioural quantise core: answers core_delay cycles after start.
    initial begin
        bus.q_done  = 1'b0;
        bus.q_besti = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !bus.q_start) begin
                core_cnt    = 0;
                bus.q_done  = 1'b0;
            end else begin
                core_cnt++;
                if (!core_hang && core_cnt == core_delay) begin
                    bus.q_done  = 1'b1;
                    bus.q_besti = core_fix_en ? core_fix : model_besti(bus.q_x, bus.q_order);
                end else begin
                    bus.q_done = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on done, grant one-hot, start spacing, latency.
    initial begin
        logic prev_q_done  = 1'b0;
        logic prev_q_start = 1'b0;
        int   low_len      = 0;
        int   jobs         = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("grant_onehot", $onehot0(bus.grant), 1);
                if (bus.done != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", bus.done, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("done_idx%0d", e.idx), bus.done, 64'(1) << e.idx);
                        check($sformatf("besti_req%0d", e.idx), bus.besti, e.besti);
                        check($sformatf("err_req%0d", e.idx), bus.err, e.err);
                        if (!e.err) check("done_latency", prev_q_done, 1);
                        if (rearm[e.idx] > 0) rearm[e.idx]--;
                        else req_b[e.idx] = 1'b0;
                    end
                end
                if (bus.q_start && !prev_q_start) begin
                    if (jobs > 0) check("start_gap_ge2", low_len >= 2, 1);
                    jobs++;
                end
            end
            low_len      = bus.q_start ? 0 : low_len + 1;
            prev_q_start = bus.q_start;
            prev_q_done  = bus.q_done;
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    // Directed sequence
    initial begin
        logic [N-1:0] x0, x1, xs;
        int n;
        for (int k = 0; k < NREQ; k++) begin req_b[k] = 1'b0; rearm[k] = 0; end
        bus.req_m = '0; bus.req_order = '0; bus.req_x = '0;

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_besti", bus.besti, 0);
        check("rst_err", bus.err, 0);
        check("rst_q_start", bus.q_start, 0);
        check("rst_q_m", bus.q_m, 0);
        check("rst_q_order", bus.q_order, 0);
        check("rst_q_x", bus.q_x, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single request, fixed core answer 3 after 20 cycles
        core_fix_en = 1'b1; core_fix = 4'd3; core_delay = 20;
        drive_op(0, M16, 4'd0, 32'h00FA_0000);
        push(0, 4'd3, 1'b0);
        req_b[0] = 1'b1;
        @(negedge clk);
        check("A_grant_p1", bus.grant, 4'b0001);
        check("A_qstart_p1", bus.q_start, 0);
        @(negedge clk);
        check("A_qstart_p2", bus.q_start, 1);
        check("A_q_m", bus.q_m, M16);
        check("A_q_order", bus.q_order, 0);
        check("A_q_x", bus.q_x, 32'h00FA_0000);
        wait_drain("A_drain", 100);
        @(negedge clk);
        check("A_done_cleared", bus.done, 0);
        check("A_grant_cleared", bus.grant, 0);
        check("A_besti_held", bus.besti, 3);
        core_fix_en = 1'b0;

        // All four at once from reset: order 0,1,2,3
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        core_delay = 4;
        for (int k = 0; k < NREQ; k++) begin
            xs = 32'h0001_0000 * (k + 2) + 32'(k * 3 + 1);
            drive_op(k, (k % 2) ? M8 : M4, 4'(k + 5), xs);
            push(k, model_besti(xs, 4'(k + 5)), 1'b0);
        end
        for (int k = 0; k < NREQ; k++) req_b[k] = 1'b1;
        wait_drain("B_drain", 400);

        // Fairness: 0 re-requests, 2 and 3 hold; expect 0,2,3,0,2,3
        @(negedge clk);
        core_delay = 3;
        drive_op(0, M16, 4'd1, 32'h0007_8009);
        drive_op(2, M8,  4'd2, 32'h000C_4006);
        drive_op(3, M4,  4'd9, 32'h0003_000E);
        for (int r = 0; r < 2; r++) begin
            push(0, model_besti(32'h0007_8009, 4'd1), 1'b0);
            push(2, model_besti(32'h000C_4006, 4'd2), 1'b0);
            push(3, model_besti(32'h0003_000E, 4'd9), 1'b0);
        end
        rearm[0] = 1; rearm[2] = 1; rearm[3] = 1;
        req_b[0] = 1'b1; req_b[2] = 1'b1; req_b[3] = 1'b1;
        wait_drain("C_drain", 400);

        // Operand isolation: requester 1 moves req_x while 0 is in RUN
        @(negedge clk);
        core_delay = 30;
        x0 = 32'h0012_3405;
        x1 = 32'h0009_ABC7;
        drive_op(0, M8, 4'd2, x0);
        push(0, model_besti(x0, 4'd2), 1'b0);
        req_b[0] = 1'b1;
        wait_start("D_start0", 20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_x[1*N +: N] = $urandom;
            @(negedge clk);
            check("D_qx_frozen", bus.q_x, x0);
        end
        drive_op(1, M4, 4'd5, x1);
        push(1, model_besti(x1, 4'd5), 1'b0);
        req_b[1] = 1'b1;
        for (int c = 0; c < 200 && !(bus.q_start && bus.grant == 4'b0010); c++) @(negedge clk);
        check("D_grant1_run", bus.grant, 4'b0010);
        check("D_q_x_req1", bus.q_x, x1);
        check("D_q_order_req1", bus.q_order, 5);
        wait_drain("D_drain", 200);

        // Reset mid-RUN: outputs clear at once, no done, next grant is 0
        @(negedge clk);
        core_delay = 40;
        drive_op(2, M16, 4'd7, 32'h0044_0001);
        push(2, model_besti(32'h0044_0001, 4'd7), 1'b0);
        req_b[2] = 1'b1;
        wait_start("E_start2", 20);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        sb.delete();
        req_b[2] = 1'b0;
        #1;
        check("E_rst_grant", bus.grant, 0);
        check("E_rst_done", bus.done, 0);
        check("E_rst_q_start", bus.q_start, 0);
        check("E_rst_besti", bus.besti, 0);
        check("E_rst_q_x", bus.q_x, 0);
        check("E_rst_q_m", bus.q_m, 0);
        @(negedge clk);
        rst = 1'b1;
        core_delay = 6;
        drive_op(0, M8, 4'd3, 32'h0021_0004);
        drive_op(3, M4, 4'd6, 32'h0030_000B);
        push(0, model_besti(32'h0021_0004, 4'd3), 1'b0);
        push(3, model_besti(32'h0030_000B, 4'd6), 1'b0);
        req_b[0] = 1'b1; req_b[3] = 1'b1;
        @(negedge clk);
        check("E_first_grant", bus.grant, 4'b0001);
        wait_drain("E_drain", 200);

`ifdef QUANT_ARB_TIMEOUT_EN
        // Core never answers: done with err at RUN+TO, back to IDLE
        @(negedge clk);
        core_hang = 1'b1;
        drive_op(1, M16, 4'd4, 32'h0055_0000);
        push(1, 4'd0, 1'b1);
        req_b[1] = 1'b1;
        wait_start("F_start1", 20);
        n = 0;
        for (int c = 0; c < 200 && bus.done == '0; c++) begin
            @(negedge clk);
            n++;
        end
        check("F_timeout_latency", n, TO);
        wait_drain("F_drain", 10);
        @(negedge clk);
        check("F_idle_grant", bus.grant, 0);
        core_hang = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
